bidir_shift_seq: RTL

Command-driven sequencer for the team's bidirectional shift register (`D_SIZE` wide, serial `in`, `en`, `dir`, `rst`, parallel `out`). It accepts one shift job per valid/ready handshake. It then drives the register's control pins for a programmed number of cycles, feeding serial bits from a command word, and returns the register's final parallel contents with a one-cycle done pulse. It sits between a host/CPU-side command source and the shift register instance.

---
 rtl/bidir_shift_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bidir_shift_seq.sv
// Command-driven sequencer for a bidirectional shift register.
// Accepts one shift job per handshake, drives the register pins, returns its contents.
module bidir_shift_seq #(
    parameter int D_SIZE  = 4,
    parameter int MAX_CNT = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [CNT_W-1:0]   cmd_cnt,
    input  logic [MAX_CNT-1:0] cmd_data,
    input  logic               cmd_clr,
    input  logic               abort,
    output logic               sr_en,
    output logic               sr_dir,
    output logic               sr_in,
    output logic               sr_rst,
    input  logic [D_SIZE-1:0]  sr_out,
    output logic               busy,
    output logic               done,
    output logic [D_SIZE-1:0]  result
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLR     = 2'd1,
        S_SHIFT   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAX_CNT = CNT_W'(MAX_CNT);

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_dir;
    logic                 r_clr;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_idx;
    logic [MAX_CNT-1:0]   r_data;
    logic                 r_done;
    logic [D_SIZE-1:0]    r_result;

    logic                 w_idle;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_cnt_clamped;
    logic [CNT_W-1:0]     w_idx_nxt;
    logic [MAX_CNT-1:0]   w_bit_mask;
    logic                 w_data_bit;
    logic                 w_capture_ok;

    // Command qualification and per-shift serial bit selection
    assign w_idle        = (r_state == S_IDLE);
    assign w_accept      = cmd_valid && w_idle;
    assign w_cnt_clamped = (cmd_cnt > LP_MAX_CNT) ? LP_MAX_CNT : cmd_cnt;
    assign w_idx_nxt     = r_idx + CNT_W'(1);
    assign w_bit_mask    = MAX_CNT'(1) << r_idx;
    assign w_data_bit    = |(r_data & w_bit_mask);
    // An abort seen in CAPTURE suppresses both the done pulse and the result update
    assign w_capture_ok  = (r_state == S_CAPTURE) && !abort;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and register control pins
    always_comb begin
        w_state_nxt = r_state;
        sr_en       = 1'b0;
        sr_rst      = 1'b0;
        sr_in       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_clr) begin
                        w_state_nxt = S_CLR;
                    end else if (w_cnt_clamped != '0) begin
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_CAPTURE;
                    end
                end
            end
            S_CLR: begin
                sr_rst = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_SHIFT: begin
                sr_en = 1'b1;
                sr_in = w_data_bit;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_idx_nxt == r_cnt) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the job fields on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir  <= 1'b0;
            r_clr  <= 1'b0;
            r_cnt  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_dir  <= cmd_dir;
            r_clr  <= cmd_clr;
            r_cnt  <= w_cnt_clamped;
            r_data <= cmd_data;
        end
    end

    // Shift index: cleared on acceptance, advanced once per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (r_state == S_SHIFT) begin
            r_idx <= w_idx_nxt;
        end
    end

    // One-cycle done pulse, registered so it lands in the following IDLE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_capture_ok;
        end
    end

    // Result snapshot of the register at job end; held until the next completed job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_capture_ok) begin
            r_result <= sr_out;
        end
    end

    assign cmd_ready = w_idle;
    assign busy      = !w_idle;
    assign sr_dir    = r_dir;
    assign done      = r_done;
    assign result    = r_result;

endmodule
